vid_native_to_axis: RTL and testbench
=====================================

Name: vid_native_to_axis

Overview:
- Downstream consumer of the VDMA read-path native video outputs (vsync/hsync/de/data).
- Repacks each active line into an AXI4-Stream video beat sequence:
  - tuser marks start-of-frame (SOF).
  - tlast marks end-of-line (EOL).
- Contains a small FWFT buffer, because native video has no backpressure while the stream sink does.
- Checks line length against hactive and frame height against vactive, and reports mismatches.

Parameters:
- DSIZE, 24, pixel width in bits.
- DEPTH, 16, buffer entries; must be a power of two, minimum 4.
- CSIZE, 16, width of pixel and line counters.

Ports:
- clock  in  1  pixel clock; the only clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  when 0, no pushes occur; the buffer still drains.
- hactive  in  16  expected pixels per line.
- vactive  in  16  expected lines per frame.
- in_vsync  in  1  native vsync, active high.
- in_hsync  in  1  native hsync; informational only, not used for framing.
- in_de  in  1  native data enable.
- in_data  in  DSIZE  native pixel data.
- m_tdata  out  DSIZE  stream pixel.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tuser  out  1  SOF flag on the first pixel of a frame.
- m_tlast  out  1  EOL flag on the last pixel of a line.
- fifo_level  out  $clog2(DEPTH)+1  current buffer occupancy.
- overflow  out  1  sticky: a pixel was dropped.
- line_err  out  1  one-cycle pulse: line length differed from hactive.
- frame_err  out  1  one-cycle pulse: line count differed from vactive.

Behaviour:
- Reset:
  - All outputs are 0; fifo_level = 0.
  - Hold register is empty; sof_pend = 0; counters = 0.
  - Reset takes effect on the next clock edge. Any frame in flight is discarded.
- vsync edge: a rising edge (in_vsync & !vs_d) sets sof_pend = 1. vs_d is in_vsync registered.
- Hold register (one-pixel lookahead so EOL can be known):
  - de=1, hold empty: load the pixel; hold.sof = sof_pend; clear sof_pend.
  - de=1, hold full: push {sof, last=0, data} from hold, then load the new pixel.
  - de=0, hold full: push hold with last=1; hold becomes empty.
  - Vsync rising edge while hold is full (malformed timing): push hold with last=1 that cycle, then set sof_pend.
  - Latency: a pixel enters the buffer 1 cycle after it is sampled. It appears on m_tvalid 1 cycle later (FWFT registered output).
- enable = 0: in_de is treated as 0. A partially held pixel is still flushed with last=1.
- Buffer:
  - Push when the hold logic emits and the buffer is not full.
  - Push when full: drop the entry and set overflow (sticky until rst).
  - Pop on m_tvalid & m_tready.
  - Simultaneous push and pop when full: the push is accepted and no overflow is flagged.
  - fifo_level updates in the same cycle as the push/pop.
- Output: m_tvalid = !empty. m_tdata, m_tuser and m_tlast are stable while m_tvalid & !m_tready.
- Line check:
  - pix_cnt increments on each sampled de pixel.
  - On each last=1 push: compare pix_cnt against hactive. If they differ, pulse line_err next cycle. Reset pix_cnt.
  - Increment line_cnt, saturating at all-ones.
- Frame check:
  - On a vsync rising edge with line_cnt != 0: compare line_cnt against vactive. If they differ, pulse frame_err next cycle. Reset line_cnt.
  - The first vsync after reset is never checked.
- Counter widths: CSIZE bits. Comparisons use zero-extended hactive/vactive.
- Dropped pixels still count toward pix_cnt, so overflow does not also trigger line_err.

Decomposition:
- Package vid_axis_pkg holds:
  - typedef struct packed {logic sof; logic last; logic [DSIZE-1:0] data;} beat_t (via a parameterised width localparam);
  - localparam LVL_W.
- One sub-module: sync_fifo_fwft. It is single-clock, parameterised width/depth, and has count, full and empty outputs.

Test Plan:
- Nominal 4x3 frame:
  - Stimulus: hactive=4, vactive=3, m_tready=1; vsync pulse, then 3 lines of 4 de pixels (data 0..11).
  - Required: 12 beats with data 0..11; m_tuser only on data 0; m_tlast on 3, 7, 11; no errors.
- Backpressure:
  - Stimulus: DEPTH=16, m_tready=0 during one 20-pixel line.
  - Required: fifo_level reaches 16; overflow=1; the first 16 pixels are retained.
  - Then set m_tready=1: 16 beats with no tlast (the EOL beat was dropped).
- Short line:
  - Stimulus: hactive=4, line of 3 pixels.
  - Required: line_err pulses once, 2 cycles after de falls; the beat for pixel 3 still carries tlast.
- Frame height:
  - Stimulus: vactive=3, 2 lines, then vsync.
  - Required: frame_err pulses once; the next frame's first beat carries tuser.
- Malformed timing:
  - Stimulus: vsync rises while de=1 mid-line.
  - Required: the held pixel is pushed with tlast=1; the next pixel carries tuser=1.
- Reset mid-line:
  - Stimulus: assert rst for 1 cycle with 5 entries buffered.
  - Required: m_tvalid=0 and fifo_level=0 on the next cycle; overflow cleared.

Source files
------------

// File: rtl/vid_axis_pkg.sv
// Shared types and defaults for the native-video to AXI4-Stream bridge.
// A beat is the unit stored in the elastic buffer: frame/line markers plus one pixel.
package vid_axis_pkg;

  localparam int PIX_W      = 24;
  localparam int FIFO_DEPTH = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic             sof;
    logic             last;
    logic [PIX_W-1:0] data;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head entry is always visible on rd_data.
// A write into a full FIFO is accepted only when the head is popped in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop samples the pre-edge value of its sources.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; empty/count gate its contents and a reset would cost a flop per bit.
  always_ff @(posedge clock) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/vid_native_to_axis.sv
// Converts native vsync/de video into AXI4-Stream beats with SOF on tuser and EOL on tlast.
// A one-pixel hold register provides the lookahead that tells us a pixel ends its line.
module vid_native_to_axis
  import vid_axis_pkg::*;
#(
  parameter int DSIZE = PIX_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CSIZE = 16
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [15:0]            hactive,
  input  logic [15:0]            vactive,
  input  logic                   in_vsync,
  input  logic                   in_hsync,
  input  logic                   in_de,
  input  logic [DSIZE-1:0]       in_data,
  output logic [DSIZE-1:0]       m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tuser,
  output logic                   m_tlast,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic                   line_err,
  output logic                   frame_err
);

  localparam int BW = DSIZE + 2;
  localparam int CW = (CSIZE > 16) ? CSIZE : 16;
  localparam logic [CSIZE-1:0] CNT_MAX = '1;

  logic             vs_d_q;
  logic             sof_pend_q, sof_pend_d;
  logic             hold_full_q, hold_full_d;
  logic             hold_sof_q, hold_sof_d;
  logic [DSIZE-1:0] hold_data_q, hold_data_d;
  logic [CSIZE-1:0] pix_cnt_q, pix_cnt_d;
  logic [CSIZE-1:0] line_cnt_q, line_cnt_d;
  logic [CSIZE-1:0] pix_base, line_cnt_inc;
  logic             seen_vs_q, seen_vs_d;
  logic             overflow_q, overflow_d;
  logic             line_err_q, line_err_d;
  logic             frame_err_q, frame_err_d;

  logic             de_eff, vs_rise;
  logic             emit, emit_last, pop;
  logic [BW-1:0]    push_beat, head_beat;
  logic             fifo_full, fifo_empty;

  // Horizontal sync carries no framing information here.
  logic hsync_unused;
  assign hsync_unused = in_hsync;

  assign de_eff  = enable & in_de;
  assign vs_rise = in_vsync & ~vs_d_q;

  // A held pixel always leaves the hold register: replaced by a new pixel or flushed as EOL.
  assign emit      = hold_full_q;
  assign emit_last = hold_full_q & (~de_eff | vs_rise);
  assign push_beat = {hold_sof_q, emit_last, hold_data_q};

  assign pop = ~fifo_empty & m_tready;

  always_comb begin
    hold_full_d  = de_eff;
    hold_sof_d   = hold_sof_q;
    hold_data_d  = hold_data_q;
    sof_pend_d   = sof_pend_q | vs_rise;
    if (de_eff) begin
      hold_data_d = in_data;
      hold_sof_d  = sof_pend_q | vs_rise;
      sof_pend_d  = 1'b0;
    end

    pix_base  = emit_last ? '0 : pix_cnt_q;
    pix_cnt_d = pix_base;
    if (de_eff && pix_base != CNT_MAX) pix_cnt_d = pix_base + CSIZE'(1);

    line_err_d = emit_last & (CW'(pix_cnt_q) != CW'(hactive));

    line_cnt_inc = line_cnt_q;
    if (emit_last && line_cnt_q != CNT_MAX) line_cnt_inc = line_cnt_q + CSIZE'(1);

    // The flushed line of a malformed frame still belongs to the frame being closed.
    line_cnt_d  = line_cnt_inc;
    seen_vs_d   = seen_vs_q;
    frame_err_d = 1'b0;
    if (vs_rise) begin
      frame_err_d = seen_vs_q & (line_cnt_inc != '0) & (CW'(line_cnt_inc) != CW'(vactive));
      line_cnt_d  = '0;
      seen_vs_d   = 1'b1;
    end

    overflow_d = overflow_q | (emit & fifo_full & ~pop);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      vs_d_q      <= 1'b0;
      sof_pend_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_sof_q  <= 1'b0;
      hold_data_q <= '0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      seen_vs_q   <= 1'b0;
      overflow_q  <= 1'b0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      vs_d_q      <= in_vsync;
      sof_pend_q  <= sof_pend_d;
      hold_full_q <= hold_full_d;
      hold_sof_q  <= hold_sof_d;
      hold_data_q <= hold_data_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      seen_vs_q   <= seen_vs_d;
      overflow_q  <= overflow_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .rst     (rst),
    .wr_en   (emit),
    .wr_data (push_beat),
    .rd_en   (pop),
    .rd_data (head_beat),
    .count   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Stale storage contents never reach the port while the buffer is empty.
  assign m_tvalid = ~fifo_empty;
  assign {m_tuser, m_tlast, m_tdata} = fifo_empty ? BW'(0) : head_beat;

  assign overflow  = overflow_q;
  assign line_err  = line_err_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_vid_native_to_axis.sv
// Self-checking bench for vid_native_to_axis: frame vector table plus corner-case sequences,
// with every expected beat queued when its pixel is driven and compared when it leaves the stream.
`timescale 1ns/1ps
module tb_vid_native_to_axis;
  import vid_axis_pkg::*;

  localparam int DSIZE = PIX_W;
  localparam int DEPTH = FIFO_DEPTH;
  localparam int CSIZE = 16;

  logic             clock = 1'b0;
  logic             rst;
  logic             enable;
  logic [15:0]      hactive, vactive;
  logic             in_vsync, in_hsync, in_de;
  logic [DSIZE-1:0] in_data;
  logic [DSIZE-1:0] m_tdata;
  logic             m_tvalid, m_tready, m_tuser, m_tlast;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow, line_err, frame_err;

  always #5 clock = ~clock;

  vid_native_to_axis #(
    .DSIZE (DSIZE),
    .DEPTH (DEPTH),
    .CSIZE (CSIZE)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .enable     (enable),
    .hactive    (hactive),
    .vactive    (vactive),
    .in_vsync   (in_vsync),
    .in_hsync   (in_hsync),
    .in_de      (in_de),
    .in_data    (in_data),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tuser    (m_tuser),
    .m_tlast    (m_tlast),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .line_err   (line_err),
    .frame_err  (frame_err)
  );

  typedef struct {
    int hact;
    int vact;
    int nlines;
    int npix;
    int exp_line_errs;
    int exp_frame_errs;
  } vec_t;

  vec_t  vecs [6];
  beat_t exp_q [$];
  beat_t mon_beat;
  int    checks = 0;
  int    failures = 0;
  int    line_err_seen = 0;
  int    frame_err_seen = 0;
  int    le0, fe0;
  logic  exp_sof;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Stream monitor: a beat transfers at the next rising edge when valid and ready are both high.
  always @(negedge clock) begin
    if (!rst) begin
      if (line_err)  line_err_seen++;
      if (frame_err) frame_err_seen++;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", exp_q.size(), 1);
        end else begin
          mon_beat = exp_q.pop_front();
          check("beat_tdata", m_tdata, mon_beat.data);
          check("beat_tuser", m_tuser, mon_beat.sof);
          check("beat_tlast", m_tlast, mon_beat.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_beat(input logic sof, input logic last, input logic [DSIZE-1:0] data);
    beat_t b;
    b.sof  = sof;
    b.last = last;
    b.data = data;
    exp_q.push_back(b);
  endtask

  task automatic vsync_pulse();
    in_vsync = 1'b1;
    tick();
    in_vsync = 1'b0;
    tick();
    exp_sof = 1'b1;
  endtask

  // Drives one line; only the first keep_cnt pixels are expected to survive the buffer.
  task automatic drive_line(input int npix, input int base, input int keep_cnt);
    for (int i = 0; i < npix; i++) begin
      in_de   = 1'b1;
      in_data = DSIZE'(base + i);
      if (i < keep_cnt) expect_beat(exp_sof, (i == npix - 1), DSIZE'(base + i));
      exp_sof = 1'b0;
      tick();
    end
    in_de = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 400; c++) begin
      if (exp_q.size() == 0 && !m_tvalid) break;
      @(negedge clock);
    end
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_valid"}, m_tvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{4, 3, 3, 4, 0, 0};
    vecs[1] = '{4, 3, 3, 3, 3, 0};
    vecs[2] = '{4, 3, 2, 4, 0, 1};
    vecs[3] = '{6, 2, 2, 6, 0, 0};
    vecs[4] = '{5, 4, 4, 7, 4, 0};
    vecs[5] = '{8, 1, 1, 8, 0, 0};

    rst      = 1'b1;
    enable   = 1'b1;
    hactive  = 16'd4;
    vactive  = 16'd3;
    in_vsync = 1'b0;
    in_hsync = 1'b0;
    in_de    = 1'b0;
    in_data  = '0;
    m_tready = 1'b1;
    exp_sof  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    @(negedge clock);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_line_err", line_err, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tuser_tlast", {m_tuser, m_tlast}, 0);

    // Frame vectors: open with vsync, drive lines, close with vsync so the height is checked.
    for (int r = 0; r < 6; r++) begin
      le0 = line_err_seen;
      fe0 = frame_err_seen;
      hactive = 16'(vecs[r].hact);
      vactive = 16'(vecs[r].vact);
      tick();
      vsync_pulse();
      for (int l = 0; l < vecs[r].nlines; l++)
        drive_line(vecs[r].npix, r * 4096 + l * vecs[r].npix, vecs[r].npix);
      vsync_pulse();
      drain($sformatf("vec%0d_drain", r));
      repeat (2) tick();
      check($sformatf("vec%0d_line_err", r), line_err_seen - le0, vecs[r].exp_line_errs);
      check($sformatf("vec%0d_frame_err", r), frame_err_seen - fe0, vecs[r].exp_frame_errs);
      check($sformatf("vec%0d_overflow", r), overflow, 0);
    end

    // Short line: error pulse lands in the second cycle after de drops.
    le0 = line_err_seen;
    fe0 = frame_err_seen;
    hactive = 16'd4;
    vactive = 16'd1;
    vsync_pulse();
    for (int i = 0; i < 3; i++) begin
      in_de   = 1'b1;
      in_data = DSIZE'(24'h700 + i);
      expect_beat(exp_sof, (i == 2), DSIZE'(24'h700 + i));
      exp_sof = 1'b0;
      tick();
    end
    in_de = 1'b0;
    @(negedge clock);
    check("short_err_early", line_err, 0);
    tick();
    @(negedge clock);
    check("short_err_pulse", line_err, 1);
    tick();
    @(negedge clock);
    check("short_err_end", line_err, 0);
    tick();
    vsync_pulse();
    drain("short_drain");
    check("short_line_err_count", line_err_seen - le0, 1);
    check("short_frame_err_count", frame_err_seen - fe0, 0);

    // Malformed timing: vsync rises mid-line while a pixel is held.
    le0 = line_err_seen;
    fe0 = frame_err_seen;
    vsync_pulse();
    for (int i = 0; i < 6; i++) begin
      in_de    = 1'b1;
      in_data  = DSIZE'(24'h800 + i);
      in_vsync = (i == 2);
      case (i)
        0:       expect_beat(1'b1, 1'b0, DSIZE'(24'h800 + i));
        1:       expect_beat(1'b0, 1'b1, DSIZE'(24'h800 + i));
        2:       expect_beat(1'b1, 1'b0, DSIZE'(24'h800 + i));
        5:       expect_beat(1'b0, 1'b1, DSIZE'(24'h800 + i));
        default: expect_beat(1'b0, 1'b0, DSIZE'(24'h800 + i));
      endcase
      tick();
    end
    in_vsync = 1'b0;
    in_de    = 1'b0;
    exp_sof  = 1'b0;
    repeat (2) tick();
    vsync_pulse();
    drain("malformed_drain");
    check("malformed_line_err_count", line_err_seen - le0, 1);
    check("malformed_frame_err_count", frame_err_seen - fe0, 0);

    // Disabling mid-line masks de but still flushes the held pixel as end of line.
    le0 = line_err_seen;
    hactive = 16'd2;
    vsync_pulse();
    for (int i = 0; i < 4; i++) begin
      in_de   = 1'b1;
      in_data = DSIZE'(24'h900 + i);
      enable  = (i < 2);
      if (i < 2) expect_beat(i == 0, i == 1, DSIZE'(24'h900 + i));
      tick();
    end
    enable = 1'b1;
    in_de  = 1'b0;
    exp_sof = 1'b0;
    repeat (2) tick();
    vsync_pulse();
    drain("enable_drain");
    check("enable_line_err_count", line_err_seen - le0, 0);

    // Backpressure: a 20-pixel line into a 16-entry buffer with the sink stalled.
    le0 = line_err_seen;
    hactive  = 16'd20;
    vactive  = 16'd1;
    m_tready = 1'b0;
    vsync_pulse();
    drive_line(20, 24'hA00, DEPTH);
    @(negedge clock);
    check("bp_level_full", fifo_level, DEPTH);
    check("bp_overflow", overflow, 1);
    check("bp_tvalid", m_tvalid, 1);
    check("bp_head_tdata", m_tdata, exp_q[0].data);
    check("bp_head_tuser", m_tuser, exp_q[0].sof);
    tick();
    m_tready = 1'b1;
    drain("bp_drain");
    check("bp_level_empty", fifo_level, 0);
    check("bp_overflow_sticky", overflow, 1);
    check("bp_line_err_count", line_err_seen - le0, 0);

    // Reset with five entries buffered discards the frame and clears the sticky flag.
    m_tready = 1'b0;
    vsync_pulse();
    for (int i = 0; i < 6; i++) begin
      in_de   = 1'b1;
      in_data = DSIZE'(24'hB00 + i);
      tick();
    end
    @(negedge clock);
    check("rstmid_level_before", fifo_level, 5);
    rst   = 1'b1;
    in_de = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clock);
    check("rstmid_tvalid", m_tvalid, 0);
    check("rstmid_level", fifo_level, 0);
    check("rstmid_overflow", overflow, 0);
    tick();

    // Recovery frame after the reset.
    le0 = line_err_seen;
    fe0 = frame_err_seen;
    m_tready = 1'b1;
    hactive  = 16'd3;
    vactive  = 16'd2;
    vsync_pulse();
    drive_line(3, 24'hC00, 3);
    drive_line(3, 24'hC03, 3);
    vsync_pulse();
    drain("recover_drain");
    repeat (2) tick();
    check("recover_line_err_count", line_err_seen - le0, 0);
    check("recover_frame_err_count", frame_err_seen - fe0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
